// File: rtl/ps2_host_tx_if.sv
// Command handshake and open-drain PS/2 line controls shared by ps2_host_tx and its owner.
// The master side is the owner plus the physical lines; the slave side is the transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clock_in, ps2_data_in,
    input  tx_ready, tx_done, tx_error, ps2_clock_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clock_in, ps2_data_in,
    output tx_ready, tx_done, tx_error, ps2_clock_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked shift, ACK.
// Define PS2_TX_RETRY_EN to retry a failed frame up to twice before reporting tx_error.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 2000
) (
  input logic          clock,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned InhibitCycles = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int unsigned TimeoutCycles = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned MaxCycles     = (InhibitCycles > TimeoutCycles) ? InhibitCycles
                                                                           : TimeoutCycles;
  localparam int unsigned CntW          = $clog2(MaxCycles) + 1;
  // INHIBIT plus the one RTS cycle keep ps2_clock low for exactly InhibitCycles.
  localparam logic [CntW-1:0] InhibitLoad = CntW'(InhibitCycles - 2);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRts, StShift, StStop, StAck, StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            data_oe_q, data_oe_d;
  logic            clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
`ifdef PS2_TX_RETRY_EN
  logic [8:0]      frame_q, frame_d;
  logic [1:0]      retry_q, retry_d;
`endif

  logic fe, cnt_zero, bus_idle, fail, retry;
  assign fe       = clk_prev_q & ~clk_sync_q;
  assign cnt_zero = (cnt_q == '0);
  assign bus_idle = clk_sync_q & dat_sync_q;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_oe_q  <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      frame_q    <= '0;
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_oe_q  <= data_oe_d;
      clk_meta_q <= bus.ps2_clock_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= bus.ps2_data_in;
      dat_sync_q <= dat_meta_q;
`ifdef PS2_TX_RETRY_EN
      frame_q    <= frame_d;
      retry_q    <= retry_d;
`endif
    end
  end

  // A device edge wins over a coincident timeout; so does a completed bus-idle.
  always_comb begin
    fail = 1'b0;
    unique case (state_q)
      StShift, StStop: fail = ~fe & cnt_zero;
      StAck:           fail = fe ? dat_sync_q : cnt_zero;
      StWaitIdle:      fail = ~bus_idle & cnt_zero;
      default:         fail = 1'b0;
    endcase
`ifdef PS2_TX_RETRY_EN
    retry = fail & (retry_q != 2'd2);
`else
    retry = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_oe_d = data_oe_q;
`ifdef PS2_TX_RETRY_EN
    frame_d   = frame_q;
    retry_d   = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef PS2_TX_RETRY_EN
        retry_d = '0;
        frame_d = {~^bus.tx_data, bus.tx_data};
`endif
        if (bus.tx_valid) begin
          shift_d   = {~^bus.tx_data, bus.tx_data};
          bit_cnt_d = '0;
          cnt_d     = InhibitLoad;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_zero) begin
          data_oe_d = 1'b1;
          state_d   = StRts;
        end
      end
      StRts: begin
        cnt_d   = TimeoutLoad;
        state_d = StShift;
      end
      StShift: begin
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = TimeoutLoad;
          if (bit_cnt_q == 4'd8) state_d = StStop;
        end
      end
      StStop: begin
        if (fe) begin
          data_oe_d = 1'b0;
          cnt_d     = TimeoutLoad;
          state_d   = StAck;
        end
      end
      StAck: begin
        if (fe && !dat_sync_q) begin
          cnt_d   = TimeoutLoad;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (bus_idle) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      data_oe_d = 1'b0;
      state_d   = StIdle;
`ifdef PS2_TX_RETRY_EN
      if (retry) begin
        state_d   = StInhibit;
        cnt_d     = InhibitLoad;
        shift_d   = frame_q;
        bit_cnt_d = '0;
        retry_d   = retry_q + 2'd1;
      end
`endif
    end
  end

  always_comb begin
    bus.tx_ready     = (state_q == StIdle);
    bus.ps2_clock_oe = (state_q == StInhibit) || (state_q == StRts);
    bus.ps2_data_oe  = data_oe_q;
    bus.tx_done      = (state_q == StWaitIdle) && bus_idle;
    bus.tx_error     = fail && !retry;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a PS/2 device model clocking frames.
module tb_ps2_host_tx;
  localparam int Inh  = 100;   // 1 MHz * 100 us
  localparam int Tmo  = 2000;  // 1 MHz * 2000 us
  localparam int Half = 20;    // device half clock period in system cycles
`ifdef PS2_TX_RETRY_EN
  localparam int Attempts = 3;
`else
  localparam int Attempts = 1;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] frame;  // {stop, parity, D7..D0, start}, bit 0 sampled first
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int total = 0;
  int bad = 0;
  int runs = 0, run_cur = 0, last_run = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  vec_t vecs [4];

  ps2_host_tx_if bus ();
  assign bus.ps2_clock_in = ~(bus.ps2_clock_oe | dev_clk_low);
  assign bus.ps2_data_in  = ~(bus.ps2_data_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(1000000),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Length of each clock-inhibit run and counts of result pulses.
  always @(negedge clock) begin
    if (bus.ps2_clock_oe) run_cur <= run_cur + 1;
    else if (run_cur != 0) begin
      last_run <= run_cur;
      runs     <= runs + 1;
      run_cur  <= 0;
    end
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.tx_error) err_cnt <= err_cnt + 1;
    if (bus.tx_done && bus.tx_error) both_cnt <= both_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic wait_clk_oe(input logic val, input int limit, input string name);
    int n = 0;
    while (bus.ps2_clock_oe !== val && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(bus.ps2_clock_oe), int'(val));
  endtask

  task automatic send(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
  endtask

  // Device side of one frame; pulses < 10 abandons it early with the lines released.
  task automatic device_frame(input logic ack, input int pulses, output int frame,
                              output int err_idx, output int done_idx,
                              output int rdy_done, output int rdy_after);
    frame = 0; err_idx = -1; done_idx = -1; rdy_done = -1; rdy_after = -1;
    wait_clk_oe(1'b1, 50, "inhibit start");
    wait_clk_oe(1'b0, Inh + 10, "clock release");
    frame[0] = bus.ps2_data_in;
    for (int i = 1; i <= pulses; i++) begin
      repeat (Half) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clock);
      dev_clk_low = 1'b0;
      frame[i] = bus.ps2_data_in;
    end
    if (pulses == 10) begin
      dev_dat_low = ack;
      repeat (Half) @(negedge clock);
      dev_clk_low = 1'b1;
      for (int k = 1; k <= Half; k++) begin
        @(negedge clock);
        if (bus.tx_error && err_idx < 0) err_idx = k;
      end
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock);
        if (bus.tx_error && err_idx < 0) err_idx = Half + k;
        if (done_idx > 0 && k == done_idx + 1) rdy_after = int'(bus.tx_ready);
        if (bus.tx_done && done_idx < 0) begin
          done_idx = k;
          rdy_done = int'(bus.tx_ready);
        end
      end
    end
  endtask

  initial begin
    int frame, ei, di, rd, ra, runs0, err0, done0, n, tries;
    vecs[0] = '{data: 8'hED, ack: 1'b1, frame: 11'b1_1_11101101_0};
    vecs[1] = '{data: 8'h01, ack: 1'b1, frame: 11'b1_0_00000001_0};
    vecs[2] = '{data: 8'hFF, ack: 1'b1, frame: 11'b1_1_11111111_0};
    vecs[3] = '{data: 8'hED, ack: 1'b0, frame: 11'b1_1_11101101_0};

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset tx_ready", int'(bus.tx_ready), 1);
    check("reset clock_oe", int'(bus.ps2_clock_oe), 0);
    check("reset data_oe", int'(bus.ps2_data_oe), 0);
    check("reset tx_done", int'(bus.tx_done), 0);
    check("reset tx_error", int'(bus.tx_error), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      tries = vecs[i].ack ? 1 : Attempts;
      for (int a = 0; a < tries; a++) begin
        runs0 = runs; err0 = err_cnt; done0 = done_cnt;
        if (a == 0) send(vecs[i].data);
        device_frame(vecs[i].ack, 10, frame, ei, di, rd, ra);
        check($sformatf("v%0d.%0d inhibit length", i, a), last_run, Inh);
        check($sformatf("v%0d.%0d inhibit runs", i, a), runs - runs0, 1);
        check($sformatf("v%0d.%0d frame bits", i, a), frame, int'(vecs[i].frame));
        check($sformatf("v%0d.%0d error index", i, a), ei,
              (vecs[i].ack || a != tries - 1) ? -1 : 2);
        check($sformatf("v%0d.%0d error pulses", i, a), err_cnt - err0,
              (vecs[i].ack || a != tries - 1) ? 0 : 1);
        check($sformatf("v%0d.%0d done index", i, a), di, vecs[i].ack ? 2 : -1);
        check($sformatf("v%0d.%0d done pulses", i, a), done_cnt - done0, vecs[i].ack ? 1 : 0);
        if (vecs[i].ack) begin
          check($sformatf("v%0d ready at done", i), rd, 0);
          check($sformatf("v%0d ready after done", i), ra, 1);
        end
      end
      repeat (5) @(negedge clock);
    end

    // Device never clocks: timeout counted from the clock release.
    err0 = err_cnt; done0 = done_cnt;
    for (int a = 0; a < Attempts; a++) begin
      if (a == 0) send(8'hF3);
      wait_clk_oe(1'b1, 50, "timeout inhibit");
      wait_clk_oe(1'b0, Inh + 10, "timeout release");
      n = 0;
      while (!bus.tx_error && !bus.ps2_clock_oe && n < Tmo + 20) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("timeout cycles attempt %0d", a), n, (a == Attempts - 1) ? Tmo : Tmo + 1);
    end
    check("timeout error level", int'(bus.tx_error), 1);
    check("timeout clock_oe", int'(bus.ps2_clock_oe), 0);
    @(negedge clock);
    check("post-timeout data_oe", int'(bus.ps2_data_oe), 0);
    check("post-timeout ready", int'(bus.tx_ready), 1);
    check("timeout error pulses", err_cnt - err0, 1);
    check("timeout done pulses", done_cnt - done0, 0);
    repeat (5) @(negedge clock);

    // Reset after the fifth device edge of 0xED, then a clean 0xF3.
    send(8'hED);
    device_frame(1'b1, 5, frame, ei, di, rd, ra);
    check("pre-reset data_oe", int'(bus.ps2_data_oe), 1);
    err0 = err_cnt; done0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("mid-reset clock_oe", int'(bus.ps2_clock_oe), 0);
    check("mid-reset data_oe", int'(bus.ps2_data_oe), 0);
    check("mid-reset ready", int'(bus.tx_ready), 1);
    check("mid-reset done", int'(bus.tx_done), 0);
    check("mid-reset error", int'(bus.tx_error), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset glitch pulses", (err_cnt - err0) + (done_cnt - done0), 0);
    send(8'hF3);
    device_frame(1'b1, 10, frame, ei, di, rd, ra);
    check("after-reset frame", frame, int'(11'b1_1_11110011_0));
    check("after-reset done index", di, 2);
    repeat (5) @(negedge clock);

    // tx_valid held through a busy frame: second frame only once ready returns.
    runs0 = runs;
    bus.tx_data  = 8'h01;
    bus.tx_valid = 1'b1;
    @(negedge clock);
    device_frame(1'b1, 10, frame, ei, di, rd, ra);
    check("held frame bits", frame, int'(11'b1_0_00000001_0));
    check("held done index", di, 2);
    check("held ready after done", ra, 1);
    check("held runs during frame", runs - runs0, 1);
    bus.tx_valid = 1'b0;
    device_frame(1'b1, 10, frame, ei, di, rd, ra);
    check("second frame bits", frame, int'(11'b1_0_00000001_0));
    check("second done index", di, 2);
    check("total held runs", runs - runs0, 2);
    repeat (5) @(negedge clock);

    check("done and error together", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
